// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for a 5-stage MIPS pipeline,
// including load-use bubbles, taken-branch flushes and bounded data-memory waits.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic             branch_taken,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       erdrt,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mrdrt,
    input  logic             mreq,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frc, mwait, lu_stall, stall;

    function automatic logic [1:0] fwd(input logic [4:0] r);
        return (ewreg & ~em2reg & (erdrt != 5'd0) & (erdrt == r)) ? 2'b01 :
               (mwreg & ~mm2reg & (mrdrt != 5'd0) & (mrdrt == r)) ? 2'b10 :
               (mwreg &  mm2reg & (mrdrt != 5'd0) & (mrdrt == r)) ? 2'b11 : 2'b00;
    endfunction

    // Forced release on the last allowed wait cycle keeps a dead memory from hanging the core
    assign frc      = (state_q == MEM_WAIT) && (wcnt_q == LAST);
    assign mwait    = mreq & ~mem_ready & ~frc;
    assign lu_stall = ewreg & em2reg & (erdrt != 5'd0) &
                      ((use_rs & (erdrt == rs)) | (use_rt & (erdrt == rt)));
    assign stall    = mwait | lu_stall;

    assign pc_en        = ~stall;
    assign ifid_en      = ~stall;
    assign ifid_flush   = ~stall & branch_taken;
    assign idex_bubble  = ~mwait & lu_stall;
    assign exmem_en     = ~mwait;
    assign memwb_bubble = mwait;
    assign fwda         = fwd(rs);
    assign fwdb         = fwd(rt);
    assign mem_timeout  = timeout_q;
    assign stall_cnt    = cnt_q;

    always_comb begin
        state_d   = mwait ? MEM_WAIT : RUN;
        wcnt_d    = (state_q == MEM_WAIT && mwait) ? wcnt_q + 8'd1 : 8'd0;
        timeout_d = timeout_q | frc;
        cnt_d     = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            wcnt_q    <= 8'd0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations for the hazard controller.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0, rst;
    logic [4:0] rs, rt, erdrt, mrdrt;
    logic use_rs, use_rt, branch_taken, ewreg, em2reg, mwreg, mm2reg, mreq, mem_ready;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble, mem_timeout;
    logic [1:0] fwda, fwdb;
    logic [3:0] stall_cnt;
    logic [5:0] ctl;
    int n_vec = 0, n_bad = 0;

    // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble}
    localparam logic [5:0] C_RUN = 6'b110010;
    localparam logic [5:0] C_MW  = 6'b000001;
    localparam logic [5:0] C_LU  = 6'b000110;
    localparam logic [5:0] C_BR  = 6'b111010;

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .branch_taken(branch_taken), .ewreg(ewreg), .em2reg(em2reg), .erdrt(erdrt),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrdrt(mrdrt), .mreq(mreq), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .fwda(fwda), .fwdb(fwdb),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    assign ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        {rs, rt, erdrt, mrdrt} = '0;
        {use_rs, use_rt, branch_taken, ewreg, em2reg, mwreg, mm2reg, mreq, mem_ready} = '0;
    endtask

    task automatic probe;
        #3;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        probe();
        chk("reset_ctl", ctl, C_RUN);
        chk("reset_cnt", stall_cnt, 0);
        chk("reset_to", mem_timeout, 0);
        // load-use: lw $5 in EX, ID reads rs=5
        tick();
        ewreg = 1; em2reg = 1; erdrt = 5; rs = 5; use_rs = 1;
        probe();
        chk("lu_ctl", ctl, C_LU);
        use_rs = 0;
        probe();
        chk("lu_unused", ctl, C_RUN);
        use_rs = 1;
        tick();
        ewreg = 0; em2reg = 0; erdrt = 0; mwreg = 1; mm2reg = 1; mrdrt = 5;
        probe();
        chk("lu_next_ctl", ctl, C_RUN);
        chk("lu_fwda", fwda, 2'b11);
        chk("lu_cnt", stall_cnt, 1);
        // forwarding priority and $0
        tick();
        idle();
        ewreg = 1; erdrt = 3; mwreg = 1; mrdrt = 3; rs = 3; rt = 3;
        probe();
        chk("fwd_ex_a", fwda, 2'b01);
        chk("fwd_ex_b", fwdb, 2'b01);
        ewreg = 0;
        probe();
        chk("fwd_mem_a", fwda, 2'b10);
        mm2reg = 1; rs = 7;
        probe();
        chk("fwd_ld_b", fwdb, 2'b11);
        chk("fwd_none_a", fwda, 2'b00);
        ewreg = 1; erdrt = 0; mrdrt = 0; rs = 0; rt = 0;
        probe();
        chk("fwd_r0", {fwda, fwdb}, 4'b0000);
        // memory wait of three cycles then ready
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0; mreq = 1;
        for (int i = 0; i < 3; i++) begin
            probe();
            chk($sformatf("mw_ctl%0d", i), ctl, C_MW);
            tick();
        end
        mem_ready = 1;
        probe();
        chk("mw_release", ctl, C_RUN);
        tick();
        mreq = 0; mem_ready = 0;
        probe();
        chk("mw_cnt", stall_cnt, 3);
        chk("mw_to", mem_timeout, 0);
        // timeout: memory never ready
        mreq = 1;
        for (int i = 0; i < 4; i++) begin
            probe();
            chk($sformatf("to_ctl%0d", i), ctl, C_MW);
            tick();
        end
        probe();
        chk("to_force", ctl, C_RUN);
        chk("to_flag_pre", mem_timeout, 0);
        tick();
        probe();
        chk("to_flag", mem_timeout, 1);
        chk("to_reenter", ctl, C_MW);
        tick();
        mreq = 0;
        probe();
        chk("to_cnt", stall_cnt, 8);
        chk("to_sticky", mem_timeout, 1);
        // branch coincident with load-use, then alone
        ewreg = 1; em2reg = 1; erdrt = 9; rt = 9; use_rt = 1; branch_taken = 1;
        probe();
        chk("br_lu", ctl, C_LU);
        tick();
        ewreg = 0; em2reg = 0;
        probe();
        chk("br_flush", ctl, C_BR);
        tick();
        // saturation: 9 so far, 10 more stalls
        branch_taken = 0; ewreg = 1; em2reg = 1;
        for (int i = 0; i < 10; i++) tick();
        probe();
        chk("sat_cnt", stall_cnt, 15);
        chk("sat_to", mem_timeout, 1);
        // reset while in MEM_WAIT
        idle();
        mreq = 1;
        tick();
        tick();
        rst = 1;
        probe();
        chk("rst_mw_ctl", ctl, C_MW);
        tick();
        rst = 0; mreq = 0;
        probe();
        chk("rst_cnt", stall_cnt, 0);
        chk("rst_to", mem_timeout, 0);
        chk("rst_ctl", ctl, C_RUN);
        // fresh wait count after reset: four stalled cycles before forced release
        mreq = 1;
        for (int i = 0; i < 4; i++) tick();
        probe();
        chk("rst_fresh", ctl, C_RUN);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
